// File: rtl/mips_inst_encoder.sv
// Packs decoded MIPS operations into 32-bit instruction words tagged with their
// instruction-memory address; expands LI into one or two words.
module mips_inst_encoder #(
  parameter int unsigned            ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  restart_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [5:0]            in_op_i,
  input  logic [4:0]            in_rs_i,
  input  logic [4:0]            in_rt_i,
  input  logic [4:0]            in_rw_i,
  input  logic [31:0]           in_imm_i,
  input  logic [ADDR_WIDTH-1:0] in_target_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [31:0]           out_inst_o,
  output logic [ADDR_WIDTH-1:0] out_addr_o,
  output logic                  err_o
);

  localparam logic [5:0] OpAdd  = 6'd0,  OpAddu  = 6'd1,  OpSub  = 6'd2,  OpSubu = 6'd3;
  localparam logic [5:0] OpAnd  = 6'd4,  OpOr    = 6'd5,  OpXor  = 6'd6,  OpNor  = 6'd7;
  localparam logic [5:0] OpSlt  = 6'd8,  OpSltu  = 6'd9,  OpSll  = 6'd10, OpSrl  = 6'd11;
  localparam logic [5:0] OpSra  = 6'd12, OpSllv  = 6'd13, OpSrlv = 6'd14, OpSrav = 6'd15;
  localparam logic [5:0] OpAddi = 6'd16, OpAddiu = 6'd17, OpAndi = 6'd18, OpOri  = 6'd19;
  localparam logic [5:0] OpXori = 6'd20, OpSlti  = 6'd21, OpSltiu = 6'd22, OpLui = 6'd23;
  localparam logic [5:0] OpBeq  = 6'd24, OpBne   = 6'd25, OpLw   = 6'd26, OpSw   = 6'd27;
  localparam logic [5:0] OpJ    = 6'd28, OpJal   = 6'd29, OpJr   = 6'd30, OpJalr = 6'd31;
  localparam logic [5:0] OpLi   = 6'd32;

  typedef enum logic [0:0] {StIdle, StLiLo} state_e;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] funct);
    return {6'd0, rs, rt, rd, sh, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [31:0]             out_inst_q, out_inst_d;
  logic [ADDR_WIDTH-1:0]   out_addr_q, out_addr_d;
  logic                    err_q, err_d;
  logic [4:0]              li_rw_q, li_rw_d;
  logic [15:0]             li_lo_q, li_lo_d;

  logic                    handoff, accept;
  logic [ADDR_WIDTH-1:0]   cnt_inc, cur_addr, pc4, br_diff;
  logic signed [ADDR_WIDTH-1:0] br_off;
  logic signed [31:0]      off32;
  logic [31:0]             tgt32;
  logic [3:0]              pc4_hi;
  logic                    fits16, hi_zero, shamt_bad, br_ok, j_ok;
  logic [31:0]             enc_inst;
  logic                    enc_bad, li_two;

  assign handoff    = out_valid_q && out_ready_i;
  assign in_ready_o = (state_q == StIdle) && (!out_valid_q || out_ready_i) && !restart_i;
  assign accept     = in_valid_i && in_ready_o;

  // A word accepted in the same cycle as a handoff lands one slot past the counter.
  assign cnt_inc  = cnt_q + ADDR_WIDTH'(4);
  assign cur_addr = handoff ? cnt_inc : cnt_q;
  assign pc4      = cur_addr + ADDR_WIDTH'(4);

  assign br_diff = in_target_i - pc4;
  assign br_off  = $signed(br_diff) >>> 2;
  assign off32   = 32'(br_off);
  assign br_ok   = (in_target_i[1:0] == 2'b00) &&
                   ((off32[31:15] == '0) || (off32[31:15] == '1));

  // Bits above ADDR_WIDTH are zero on both sides, so the 256 MB region check is
  // a no-op for narrow address spaces.
  assign tgt32  = 32'(in_target_i);
  assign pc4_hi = 4'(32'(pc4) >> 28);
  assign j_ok   = (tgt32[1:0] == 2'b00) && (tgt32[31:28] == pc4_hi);

  assign fits16    = (in_imm_i[31:15] == '0) || (in_imm_i[31:15] == '1);
  assign hi_zero   = (in_imm_i[31:16] == '0);
  assign shamt_bad = |in_imm_i[31:5];

  always_comb begin
    enc_inst = '0;
    enc_bad  = 1'b0;
    li_two   = 1'b0;
    case (in_op_i)
      OpAdd:   enc_inst = r_word(in_rs_i, in_rt_i, in_rw_i, 5'd0, 6'h20);
      OpAddu:  enc_inst = r_word(in_rs_i, in_rt_i, in_rw_i, 5'd0, 6'h21);
      OpSub:   enc_inst = r_word(in_rs_i, in_rt_i, in_rw_i, 5'd0, 6'h22);
      OpSubu:  enc_inst = r_word(in_rs_i, in_rt_i, in_rw_i, 5'd0, 6'h23);
      OpAnd:   enc_inst = r_word(in_rs_i, in_rt_i, in_rw_i, 5'd0, 6'h24);
      OpOr:    enc_inst = r_word(in_rs_i, in_rt_i, in_rw_i, 5'd0, 6'h25);
      OpXor:   enc_inst = r_word(in_rs_i, in_rt_i, in_rw_i, 5'd0, 6'h26);
      OpNor:   enc_inst = r_word(in_rs_i, in_rt_i, in_rw_i, 5'd0, 6'h27);
      OpSlt:   enc_inst = r_word(in_rs_i, in_rt_i, in_rw_i, 5'd0, 6'h2a);
      OpSltu:  enc_inst = r_word(in_rs_i, in_rt_i, in_rw_i, 5'd0, 6'h2b);
      OpSll: begin
        enc_inst = r_word(5'd0, in_rs_i, in_rw_i, in_imm_i[4:0], 6'h00);
        enc_bad  = shamt_bad;
      end
      OpSrl: begin
        enc_inst = r_word(5'd0, in_rs_i, in_rw_i, in_imm_i[4:0], 6'h02);
        enc_bad  = shamt_bad;
      end
      OpSra: begin
        enc_inst = r_word(5'd0, in_rs_i, in_rw_i, in_imm_i[4:0], 6'h03);
        enc_bad  = shamt_bad;
      end
      OpSllv:  enc_inst = r_word(in_rs_i, in_rt_i, in_rw_i, 5'd0, 6'h04);
      OpSrlv:  enc_inst = r_word(in_rs_i, in_rt_i, in_rw_i, 5'd0, 6'h06);
      OpSrav:  enc_inst = r_word(in_rs_i, in_rt_i, in_rw_i, 5'd0, 6'h07);
      OpAddi: begin
        enc_inst = i_word(6'h08, in_rs_i, in_rw_i, in_imm_i[15:0]);
        enc_bad  = !fits16;
      end
      OpAddiu: begin
        enc_inst = i_word(6'h09, in_rs_i, in_rw_i, in_imm_i[15:0]);
        enc_bad  = !fits16;
      end
      OpAndi: begin
        enc_inst = i_word(6'h0c, in_rs_i, in_rw_i, in_imm_i[15:0]);
        enc_bad  = !hi_zero;
      end
      OpOri: begin
        enc_inst = i_word(6'h0d, in_rs_i, in_rw_i, in_imm_i[15:0]);
        enc_bad  = !hi_zero;
      end
      OpXori: begin
        enc_inst = i_word(6'h0e, in_rs_i, in_rw_i, in_imm_i[15:0]);
        enc_bad  = !hi_zero;
      end
      OpSlti: begin
        enc_inst = i_word(6'h0a, in_rs_i, in_rw_i, in_imm_i[15:0]);
        enc_bad  = !fits16;
      end
      OpSltiu: begin
        enc_inst = i_word(6'h0b, in_rs_i, in_rw_i, in_imm_i[15:0]);
        enc_bad  = !fits16;
      end
      OpLui:   enc_inst = i_word(6'h0f, 5'd0, in_rw_i, in_imm_i[15:0]);
      OpBeq: begin
        enc_inst = i_word(6'h04, in_rs_i, in_rt_i, off32[15:0]);
        enc_bad  = !br_ok;
      end
      OpBne: begin
        enc_inst = i_word(6'h05, in_rs_i, in_rt_i, off32[15:0]);
        enc_bad  = !br_ok;
      end
      OpLw: begin
        enc_inst = i_word(6'h23, in_rs_i, in_rw_i, in_imm_i[15:0]);
        enc_bad  = !fits16;
      end
      OpSw: begin
        enc_inst = i_word(6'h2b, in_rs_i, in_rt_i, in_imm_i[15:0]);
        enc_bad  = !fits16;
      end
      OpJ: begin
        enc_inst = {6'h02, tgt32[27:2]};
        enc_bad  = !j_ok;
      end
      OpJal: begin
        enc_inst = {6'h03, tgt32[27:2]};
        enc_bad  = !j_ok;
      end
      OpJr:    enc_inst = r_word(in_rs_i, 5'd0, 5'd0, 5'd0, 6'h08);
      OpJalr:  enc_inst = r_word(in_rs_i, 5'd0, 5'd31, 5'd0, 6'h09);
      OpLi: begin
        if (fits16) begin
          enc_inst = i_word(6'h09, 5'd0, in_rw_i, in_imm_i[15:0]);
        end else begin
          enc_inst = i_word(6'h0f, 5'd0, in_rw_i, in_imm_i[31:16]);
          li_two   = |in_imm_i[15:0];
        end
      end
      default: enc_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_addr_d  = out_addr_q;
    err_d       = 1'b0;
    li_rw_d     = li_rw_q;
    li_lo_d     = li_lo_q;
    if (restart_i) begin
      state_d     = StIdle;
      cnt_d       = BASE_ADDR;
      out_valid_d = 1'b0;
    end else begin
      if (handoff) begin
        cnt_d       = cnt_inc;
        out_valid_d = 1'b0;
      end
      if (state_q == StLiLo) begin
        // The LUI half is always pending here; follow it with ORI once it leaves.
        if (handoff) begin
          out_valid_d = 1'b1;
          out_inst_d  = i_word(6'h0d, li_rw_q, li_rw_q, li_lo_q);
          out_addr_d  = cnt_inc;
          state_d     = StIdle;
        end
      end else if (accept) begin
        if (enc_bad) begin
          err_d = 1'b1;
        end else begin
          out_valid_d = 1'b1;
          out_inst_d  = enc_inst;
          out_addr_d  = cur_addr;
          if (li_two) begin
            state_d = StLiLo;
            li_rw_d = in_rw_i;
            li_lo_d = in_imm_i[15:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= BASE_ADDR;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_addr_q  <= '0;
      err_q       <= 1'b0;
      li_rw_q     <= '0;
      li_lo_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_addr_q  <= out_addr_d;
      err_q       <= err_d;
      li_rw_q     <= li_rw_d;
      li_lo_q     <= li_lo_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_inst_o  = out_inst_q;
  assign out_addr_o  = out_addr_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mips_inst_encoder.sv
// Directed bench for mips_inst_encoder: expected words and error pulses are queued
// as requests are driven and matched as the encoder emits them.
module tb_mips_inst_encoder;

  logic        clk = 1'b0;
  logic        rst, restart, in_valid, in_ready, out_valid, out_ready, err;
  logic [5:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rw;
  logic [31:0] in_imm, out_inst;
  logic [15:0] in_target, out_addr;

  always #5 clk = ~clk;

  mips_inst_encoder dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .restart_i   (restart),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_op_i     (in_op),
    .in_rs_i     (in_rs),
    .in_rt_i     (in_rt),
    .in_rw_i     (in_rw),
    .in_imm_i    (in_imm),
    .in_target_i (in_target),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_inst_o  (out_inst),
    .out_addr_o  (out_addr),
    .err_o       (err)
  );

  typedef struct packed {
    logic        is_err;
    logic [31:0] inst;
    logic [15:0] addr;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_addr = 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic exp_word(input logic [31:0] inst);
    sb.push_back('{1'b0, inst, exp_addr});
    exp_addr = exp_addr + 16'd4;
  endtask

  task automatic exp_err();
    sb.push_back('{1'b1, 32'd0, 16'd0});
  endtask

  task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rw, input logic [31:0] imm, input logic [15:0] tgt);
    int   n;
    logic acc;
    in_op = op; in_rs = rs; in_rt = rt; in_rw = rw; in_imm = imm; in_target = tgt;
    in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  // Scoreboard: every emitted word or error pulse consumes one queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (err) begin
        chk("sb_has_entry_for_err", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("err_expected", 32'(e.is_err), 32'd1);
        end
      end
      if (out_valid && out_ready) begin
        chk("sb_has_entry_for_word", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("word_not_err", 32'(e.is_err), 32'd0);
          chk("out_inst", out_inst, e.inst);
          chk("out_addr", 32'(out_addr), 32'(e.addr));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rw = '0; in_imm = '0; in_target = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    out_ready = 1'b1;
    exp_word(32'h0022_1820); send(6'd0,  5'd1,  5'd2,  5'd3, 32'd0, 16'h0);          // ADD
    exp_word(32'h2404_FFFF); send(6'd17, 5'd0,  5'd0,  5'd4, 32'hFFFF_FFFF, 16'h0);  // ADDIU
    exp_word(32'h0006_28C0); send(6'd10, 5'd6,  5'd0,  5'd5, 32'd3, 16'h0);          // SLL
    exp_err();               send(6'd10, 5'd6,  5'd0,  5'd5, 32'd32, 16'h0);         // SLL bad shamt
    exp_word(32'h3022_FFFF); send(6'd18, 5'd1,  5'd0,  5'd2, 32'h0000_FFFF, 16'h0);  // ANDI
    exp_err();               send(6'd19, 5'd1,  5'd0,  5'd2, 32'h0001_0000, 16'h0);  // ORI too wide
    exp_word(32'h1020_FFFE); send(6'd24, 5'd1,  5'd0,  5'd0, 32'd0, 16'h000C);       // BEQ @0x10
    exp_err();               send(6'd24, 5'd1,  5'd0,  5'd0, 32'd0, 16'h000E);       // BEQ misaligned
    exp_word(32'hAFBF_FFFC); send(6'd27, 5'd29, 5'd31, 5'd0, 32'hFFFF_FFFC, 16'h0);  // SW
    exp_word(32'h0800_0040); send(6'd28, 5'd0,  5'd0,  5'd0, 32'd0, 16'h0100);       // J
    exp_word(32'h0C00_0040); send(6'd29, 5'd0,  5'd0,  5'd0, 32'd0, 16'h0100);       // JAL
    exp_err();               send(6'd28, 5'd0,  5'd0,  5'd0, 32'd0, 16'h0102);       // J misaligned
    exp_word(32'h03E0_0008); send(6'd30, 5'd31, 5'd0,  5'd0, 32'd0, 16'h0);          // JR
    exp_word(32'h0080_F809); send(6'd31, 5'd4,  5'd0,  5'd0, 32'd0, 16'h0);          // JALR
    exp_err();               send(6'd40, 5'd0,  5'd0,  5'd0, 32'd0, 16'h0);          // illegal op
    exp_word(32'h8D09_7FFF); send(6'd26, 5'd8,  5'd0,  5'd9, 32'h0000_7FFF, 16'h0);  // LW
    exp_word(32'h1443_0002); send(6'd25, 5'd2,  5'd3,  5'd0, 32'd0, 16'h0038);       // BNE @0x2C

    // Two-word LI: ready drops for exactly the cycle the LUI half is pending.
    exp_word(32'h3C08_1234);
    exp_word(32'h3508_5678);
    send(6'd32, 5'd0, 5'd0, 5'd8, 32'h1234_5678, 16'h0);
    @(negedge clk);
    chk("li_busy_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("li_done_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    exp_word(32'h3C08_0001); send(6'd32, 5'd0, 5'd0, 5'd8, 32'h0001_0000, 16'h0);
    exp_word(32'h2408_0005); send(6'd32, 5'd0, 5'd0, 5'd8, 32'd5, 16'h0);
    @(posedge clk); #1;

    // Backpressure: held word must stay put and block new requests.
    out_ready = 1'b0;
    exp_word(32'h0022_1820); send(6'd0, 5'd1, 5'd2, 5'd3, 32'd0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_inst", out_inst, 32'h0022_1820);
      chk("stall_addr", 32'(out_addr), 32'h0040);
      chk("stall_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Restart during LI_LO discards the pending LUI; nothing is expected from it.
    out_ready = 1'b0;
    send(6'd32, 5'd0, 5'd0, 5'd8, 32'h1234_5678, 16'h0);
    restart = 1'b1;
    @(negedge clk);
    chk("restart_blocks_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    restart = 1'b0;
    @(negedge clk);
    chk("restart_valid", 32'(out_valid), 32'd0);
    chk("restart_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    exp_addr = 16'h0000;
    exp_err();               send(6'd16, 5'd0, 5'd0, 5'd1, 32'h0001_8000, 16'h0);   // ADDI too wide
    exp_word(32'h0022_1820); send(6'd0,  5'd1, 5'd2, 5'd3, 32'd0, 16'h0);          // @BASE

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
